// File: rtl/axis_blank_gen.sv
// Receiver-blanking controller: holds `zero` during the transmit gate and for
// cfg_tail accepted beats after it. Define AXIS_BLANK_GEN_CNT_EN for blank_cnt.
module axis_blank_gen #(
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  gate,
  input  logic [CNTR_WIDTH-1:0] cfg_tail,
  input  logic                  cnt_clear,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tready,
  output logic                  zero,
  output logic                  busy,
  output logic [CNTR_WIDTH-1:0] blank_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNTR_WIDTH-1:0] tail_q, tail_d;
  logic                  zero_q, busy_q;
  logic                  beat;

  assign beat = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      tail_q  <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      zero_q  <= (state_d != IDLE);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    unique case (state_q)
      IDLE: begin
        if (gate) state_d = GATE;
      end
      GATE: begin
        if (!gate) begin
          tail_d  = cfg_tail;
          state_d = (cfg_tail == '0) ? IDLE : TAIL;
        end
      end
      TAIL: begin
        // A new gate discards the remaining tail, even on the final beat.
        if (gate) begin
          state_d = GATE;
        end else if (beat) begin
          if (tail_q == CNTR_WIDTH'(1)) begin
            state_d = IDLE;
            tail_d  = '0;
          end else begin
            tail_d = tail_q - CNTR_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tail_d  = '0;
      end
    endcase
  end

  assign zero = zero_q;
  assign busy = busy_q;

`ifdef AXIS_BLANK_GEN_CNT_EN
  logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (beat && zero_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign blank_cnt = cnt_q;
`else
  logic cnt_clear_unused;
  assign cnt_clear_unused = cnt_clear;
  assign blank_cnt        = '0;
`endif

endmodule

// File: tb/tb_axis_blank_gen.sv
// Self-checking bench for axis_blank_gen: beat-level model plus pinned literals.
module tb_axis_blank_gen;

  localparam int W      = 16;
  localparam int CNTMAX = (1 << W) - 1;

  logic         aclk;
  logic         aresetn;
  logic         gate;
  logic [W-1:0] cfg_tail;
  logic         cnt_clear;
  logic         tvalid;
  logic         tready;
  logic         zero;
  logic         busy;
  logic [W-1:0] blank_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  axis_blank_gen #(.CNTR_WIDTH(W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .gate          (gate),
    .cfg_tail      (cfg_tail),
    .cnt_clear     (cnt_clear),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .zero          (zero),
    .busy          (busy),
    .blank_cnt     (blank_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Model: blanking is on while the gate is on; after the gate falls it
  // needs cfg_tail more beats (counted from the following cycle) to end.
  bit m_zero = 1'b0;
  int m_left = -1;   // -1: gate still active, tail not yet latched
  int m_cnt  = 0;

  initial begin
    bit b;
    bit nz;
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn) begin
        m_zero = 1'b0;
        m_left = -1;
        m_cnt  = 0;
      end else begin
        b = tvalid & tready;
        if (cnt_clear)                           m_cnt = 0;
        else if (b && m_zero && m_cnt < CNTMAX)  m_cnt = m_cnt + 1;
        if (!m_zero || gate) begin
          nz     = gate;
          m_left = -1;
        end else if (m_left < 0) begin
          m_left = int'(cfg_tail);
          nz     = (m_left > 0);
        end else begin
          if (b) m_left = m_left - 1;
          nz = (m_left > 0);
        end
        m_zero = nz;
      end
    end
  end

  function automatic int exp_cnt(input int c);
`ifdef AXIS_BLANK_GEN_CNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_cmp = n_cmp + 1;
    if (got != want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge aclk);
      check("model_zero", int'(zero), int'(m_zero));
      check("model_busy", int'(busy), int'(m_zero));
      check("model_cnt",  int'(blank_cnt), exp_cnt(m_cnt));
    end
  end

  // Drive inputs just after a negedge, let a posedge sample them, return at
  // the next negedge where outputs reflect that sample.
  task automatic step(input bit g, input bit bt, input bit clr);
    gate      = g;
    tvalid    = bt;
    tready    = 1'b1;
    cnt_clear = clr;
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    aresetn   = 1'b0;
    gate      = 1'b0;
    cfg_tail  = '0;
    cnt_clear = 1'b0;
    tvalid    = 1'b0;
    tready    = 1'b0;
    @(negedge aclk);

    // Reset held with gate and beats active
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check("rst_zero", int'(zero), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt",  int'(blank_cnt), 0);
    aresetn = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("rel_zero", int'(zero), 1);
    step(1'b0, 1'b0, 1'b0);
    check("rel_fall_zero", int'(zero), 0);
    step(1'b0, 1'b0, 1'b1);

    // Basic tail: 10 gate cycles, tail 4, beat every cycle
    cfg_tail = 16'd4;
    step(1'b1, 1'b1, 1'b0);
    check("basic_rise", int'(zero), 1);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0);
    check("basic_last_on", int'(zero), 1);
    step(1'b0, 1'b1, 1'b0);
    check("basic_off", int'(zero), 0);
    check("basic_busy_off", int'(busy), 0);
    check("basic_cnt", int'(blank_cnt), exp_cnt(14));
    step(1'b0, 1'b1, 1'b0);

    // Sparse beats: tail 3, beats every 4th cycle after the fall
    cfg_tail = 16'd3;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) step(1'b0, (k % 4) == 2, 1'b0);
    check("sparse_hold", int'(zero), 1);
    step(1'b0, 1'b1, 1'b0);
    check("sparse_off", int'(zero), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Zero tail with a single-cycle pulse
    cfg_tail = 16'd0;
    step(1'b1, 1'b1, 1'b0);
    check("pulse_on", int'(zero), 1);
    step(1'b0, 1'b1, 1'b0);
    check("pulse_off", int'(zero), 0);
    step(1'b0, 1'b1, 1'b0);

    // Re-trigger inside the tail; cfg change mid-tail must not apply
    cfg_tail = 16'd10;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    cfg_tail = 16'd2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    cfg_tail = 16'd10;
    step(1'b0, 1'b1, 1'b0);
    cfg_tail = 16'd2;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    check("retrig_hold", int'(zero), 1);
    step(1'b0, 1'b1, 1'b0);
    check("retrig_off", int'(zero), 0);

    // Re-trigger on the final tail beat wins
    cfg_tail = 16'd1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("retrig_final", int'(zero), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("retrig_final_off", int'(zero), 0);

    // Reset mid-tail
    cfg_tail = 16'd8;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    aresetn = 1'b0;
    #1;
    check("midrst_zero", int'(zero), 0);
    check("midrst_cnt",  int'(blank_cnt), 0);
    step(1'b0, 1'b1, 1'b0);
    aresetn = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check("midrst_idle", int'(zero), 0);

    // Counter saturation then clear with a simultaneous beat
    cfg_tail = 16'd0;
    for (int i = 0; i < (1 << W) + 6; i++) step(1'b1, 1'b1, 1'b0);
    check("sat_cnt", int'(blank_cnt), exp_cnt(16'hFFFF));
    step(1'b1, 1'b1, 1'b1);
    check("clr_cnt", int'(blank_cnt), 0);
    step(1'b1, 1'b1, 1'b0);
    check("post_clr_cnt", int'(blank_cnt), exp_cnt(1));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
